vpu_stream: RTL and testbench

Streaming successor to the multi-channel VPU. Accepts LANES-wide partial-sum beats over valid/ready and accumulates them in a DEPTH-entry indexed psum buffer. On a beat flagged last, it applies bias, ReLU and fixed-point requantisation (scale multiply, arithmetic shift, saturate) in a stallable 3-stage pipeline. Sits between systolic-array drain and the unified buffer writeback.

---
 rtl/vpu_stream.sv | 193 +++++++++++++++++++
 tb/tb_vpu_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_stream.sv
// Streaming VPU: indexed psum accumulation, then bias/ReLU/requantise.
// Optional round-half-up requantisation: define VPU_STREAM_ROUND_EN.
module vpu_stream #(
  parameter int LANES      = 16,
  parameter int I_WIDTH    = 32,
  parameter int PSUM_WIDTH = 32,
  parameter int O_WIDTH    = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*I_WIDTH-1:0]      in_data,
  input  logic [$clog2(DEPTH)-1:0]      in_idx,
  input  logic                          in_last,
  input  logic [LANES*PSUM_WIDTH-1:0]   bias_in,
  input  logic                          cfg_bias_en,
  input  logic                          cfg_relu_en,
  input  logic [15:0]                   cfg_scale,
  input  logic [4:0]                    cfg_shift,
  input  logic                          psum_clear,
  input  logic                          ovf_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*O_WIDTH-1:0]      out_data,
  output logic                          ovf_sticky
);
  localparam int P  = PSUM_WIDTH;
  localparam int PW = PSUM_WIDTH + 17;

  localparam logic signed [PW-1:0] OMAX =
    {{(PW-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] OMIN =
    {{(PW-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  // {overflow, saturated sum}
  function automatic logic [P:0] sat_add(
    input logic [P-1:0] a,
    input logic [P-1:0] b
  );
    logic [P:0] s;
    s = {a[P-1], a} + {b[P-1], b};
    if (s[P] != s[P-1])
      sat_add = {1'b1, s[P], {(P-1){!s[P]}}};
    else
      sat_add = {1'b0, s[P-1:0]};
  endfunction

  logic                   stall;
  logic                   accept;
  logic [DEPTH-1:0]       entry_valid;
  logic [LANES*P-1:0]     psum_mem [DEPTH];
  logic                   hit;
  logic [LANES*P-1:0]     acc;
  logic                   acc_ovf;

  logic                   s2_valid;
  logic [LANES*P-1:0]     s2_acc;
  logic [LANES*P-1:0]     s2_bias;
  logic                   s2_bias_en;
  logic                   s2_relu_en;
  logic [15:0]            s2_scale;
  logic [4:0]             s2_shift;
  logic [LANES*P-1:0]     v2;
  logic                   bias_ovf;

  logic                   s3_valid;
  logic [LANES*P-1:0]     s3_v;
  logic [15:0]            s3_scale;
  logic [4:0]             s3_shift;
  logic [LANES*O_WIDTH-1:0] res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;

  // S1: accumulate onto the entry, treating a concurrent clear as empty
  always_comb begin
    logic [I_WIDTH-1:0] e;
    logic [P-1:0]       x;
    logic [P:0]         r;
    acc     = '0;
    acc_ovf = 1'b0;
    hit     = entry_valid[in_idx] && !psum_clear;
    for (int l = 0; l < LANES; l++) begin
      e = in_data[l*I_WIDTH +: I_WIDTH];
      x = {P{e[I_WIDTH-1]}};
      x[I_WIDTH-1:0] = e;
      r = sat_add(psum_mem[in_idx][l*P +: P], x);
      if (hit) begin
        acc[l*P +: P] = r[P-1:0];
        acc_ovf       = acc_ovf | r[P];
      end else begin
        acc[l*P +: P] = x;
      end
    end
  end

  // S2: optional saturating bias, then optional ReLU
  always_comb begin
    logic [P:0] r;
    v2       = s2_acc;
    bias_ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      r = sat_add(s2_acc[l*P +: P], s2_bias[l*P +: P]);
      if (s2_bias_en) begin
        v2[l*P +: P] = r[P-1:0];
        bias_ovf     = bias_ovf | (r[P] & s2_valid);
      end
      if (s2_relu_en && v2[l*P + P-1])
        v2[l*P +: P] = '0;
    end
  end

  // S3: scale, shift, saturate to the output width
  always_comb begin
    logic signed [P-1:0]  v;
    logic signed [16:0]   sc;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] r;
    res = '0;
    sc  = $signed({1'b0, s3_scale});
    for (int l = 0; l < LANES; l++) begin
      v    = $signed(s3_v[l*P +: P]);
      prod = v * sc;
`ifdef VPU_STREAM_ROUND_EN
      if (s3_shift != 5'd0)
        prod = prod + ({{(PW-1){1'b0}}, 1'b1} << (s3_shift - 5'd1));
`endif
      r = prod >>> s3_shift;
      if (r > OMAX)
        res[l*O_WIDTH +: O_WIDTH] = OMAX[O_WIDTH-1:0];
      else if (r < OMIN)
        res[l*O_WIDTH +: O_WIDTH] = OMIN[O_WIDTH-1:0];
      else
        res[l*O_WIDTH +: O_WIDTH] = r[O_WIDTH-1:0];
    end
  end

  // psum buffer storage for non-last beats (not reset)
  always_ff @(posedge clk) begin
    if (accept && !in_last)
      psum_mem[in_idx] <= acc;
  end

  // pipeline data registers, advanced when not stalled
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept && in_last) begin
        s2_acc     <= acc;
        s2_bias    <= bias_in;
        s2_bias_en <= cfg_bias_en;
        s2_relu_en <= cfg_relu_en;
        s2_scale   <= cfg_scale;
        s2_shift   <= cfg_shift;
      end
      if (s2_valid) begin
        s3_v     <= v2;
        s3_scale <= s2_scale;
        s3_shift <= s2_shift;
      end
    end
  end

  // control state: entry valids, stage valids, output, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= '0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      ovf_sticky <= (ovf_sticky && !ovf_clear)
                  || (accept && acc_ovf)
                  || (!stall && bias_ovf);
      if (psum_clear)
        entry_valid <= '0;
      if (accept)
        entry_valid[in_idx] <= !in_last;
      if (!stall) begin
        s2_valid  <= accept && in_last;
        s3_valid  <= s2_valid;
        out_valid <= s3_valid;
        if (s3_valid)
          out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_vpu_stream.sv
// Directed self-checking bench for vpu_stream.
// Expected values are hand-computed per scenario.
module tb_vpu_stream;
  localparam int LANES = 16;
  localparam int IW    = 32;
  localparam int PW    = 32;
  localparam int OW    = 8;
  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IW-1:0]   in_data;
  logic [3:0]            in_idx;
  logic                  in_last;
  logic [LANES*PW-1:0]   bias_in;
  logic                  cfg_bias_en;
  logic                  cfg_relu_en;
  logic [15:0]           cfg_scale;
  logic [4:0]            cfg_shift;
  logic                  psum_clear;
  logic                  ovf_clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   out_data;
  logic                  ovf_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  vpu_stream #(
    .LANES(LANES), .I_WIDTH(IW), .PSUM_WIDTH(PW),
    .O_WIDTH(OW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_idx(in_idx), .in_last(in_last),
    .bias_in(bias_in), .cfg_bias_en(cfg_bias_en),
    .cfg_relu_en(cfg_relu_en), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .psum_clear(psum_clear),
    .ovf_clear(ovf_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic int lane(input int l);
    logic signed [OW-1:0] v;
    v = out_data[l*OW +: OW];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one beat for a single cycle; returns 1 time unit after the edge
  task automatic send(
    input int idx, input logic last,
    input int l0, input int l1, input int l2,
    input int b0, input int b1,
    input logic ben, input logic relu,
    input int scale, input int shift, input logic clr
  );
    in_valid    = 1'b1;
    in_idx      = idx[3:0];
    in_last     = last;
    in_data     = '0;
    in_data[0*IW +: IW] = l0;
    in_data[1*IW +: IW] = l1;
    in_data[2*IW +: IW] = l2;
    bias_in     = '0;
    bias_in[0*PW +: PW] = b0;
    bias_in[1*PW +: PW] = b1;
    cfg_bias_en = ben;
    cfg_relu_en = relu;
    cfg_scale   = scale[15:0];
    cfg_shift   = shift[4:0];
    psum_clear  = clr;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    psum_clear = 1'b0;
  endtask

  // cycles until out_valid, capped at 20
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_chk++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data got %h want 0", out_data);
    end
    n_chk++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_sticky);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_saturate_out();
    int cyc;
    send(0, 1, 100, 300, -300, 0, 0, 0, 0, 1, 0, 0);
    wait_out(cyc);
    n_chk++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL t1_latency got %0d want 2", cyc);
    end
    n_chk++;
    if (lane(0) !== 100) begin
      n_fail++; $display("FAIL t1_lane0 got %0d want 100", lane(0));
    end
    n_chk++;
    if (lane(1) !== 127) begin
      n_fail++; $display("FAIL t1_lane1 got %0d want 127", lane(1));
    end
    n_chk++;
    if (lane(2) !== -128) begin
      n_fail++; $display("FAIL t1_lane2 got %0d want -128", lane(2));
    end
    n_chk++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL t1_ovf got %b want 0", ovf_sticky);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_single_pulse got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp;
`ifdef VPU_STREAM_ROUND_EN
    exp = 46;
`else
    exp = 45;
`endif
    send(2, 0, 20, 0, 0, 0, 0, 0, 0, 3, 2, 0);
    send(2, 0, 20, 0, 0, 0, 0, 0, 0, 3, 2, 0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t2_no_out_nonlast got %b want 0", out_valid);
    end
    send(2, 1, 21, 0, 0, 0, 0, 0, 0, 3, 2, 0);
    wait_out(cyc);
    n_chk++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL t2_latency got %0d want 2", cyc);
    end
    n_chk++;
    if (lane(0) !== exp) begin
      n_fail++; $display("FAIL t2_lane0 got %0d want %0d", lane(0), exp);
    end
    tick();
  endtask

  task automatic test_bias_relu();
    int cyc;
    send(5, 1, -50, 10, 0, 20, 5, 1, 1, 1, 0, 0);
    wait_out(cyc);
    n_chk++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL t3_latency got %0d want 2", cyc);
    end
    n_chk++;
    if (lane(0) !== 0) begin
      n_fail++; $display("FAIL t3_lane0 got %0d want 0", lane(0));
    end
    n_chk++;
    if (lane(1) !== 15) begin
      n_fail++; $display("FAIL t3_lane1 got %0d want 15", lane(1));
    end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(6, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    send(7, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    send(8, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || lane(0) !== 1) begin
        n_fail++;
        $display("FAIL t4_hold cyc %0d got v=%b d=%0d want v=1 d=1",
                 i, out_valid, lane(0));
      end
      n_chk++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL t4_in_ready cyc %0d got %b want 0", i, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || lane(0) !== 2) begin
      n_fail++;
      $display("FAIL t4_drain2 got v=%b d=%0d want v=1 d=2", out_valid, lane(0));
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || lane(0) !== 3) begin
      n_fail++;
      $display("FAIL t4_drain3 got v=%b d=%0d want v=1 d=3", out_valid, lane(0));
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t4_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_acc_saturate();
    int cyc;
    send(3, 0, 32'h7000_0000, 0, 0, 0, 0, 0, 0, 1, 24, 0);
    n_chk++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL t5_ovf_early got %b want 0", ovf_sticky);
    end
    send(3, 1, 32'h7000_0000, 0, 0, 0, 0, 0, 0, 1, 24, 0);
    n_chk++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL t5_ovf_set got %b want 1", ovf_sticky);
    end
    wait_out(cyc);
    n_chk++;
    if (out_valid !== 1'b1 || lane(0) !== 127) begin
      n_fail++;
      $display("FAIL t5_lane0 got v=%b d=%0d want v=1 d=127", out_valid, lane(0));
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    n_chk++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL t5_ovf_clear got %b want 0", ovf_sticky);
    end
  endtask

  task automatic test_psum_clear();
    int cyc;
    send(1, 0, 500, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    send(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    wait_out(cyc);
    n_chk++;
    if (out_valid !== 1'b1 || lane(0) !== 7) begin
      n_fail++;
      $display("FAIL t6_lane0 got v=%b d=%0d want v=1 d=7", out_valid, lane(0));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send(4, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid cyc %0d got %b want 0", i, out_valid);
      end
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_idx      = '0;
    in_last     = 1'b0;
    bias_in     = '0;
    cfg_bias_en = 1'b0;
    cfg_relu_en = 1'b0;
    cfg_scale   = 16'd1;
    cfg_shift   = 5'd0;
    psum_clear  = 1'b0;
    ovf_clear   = 1'b0;
    out_ready   = 1'b1;
    #1;
    test_reset();
    test_saturate_out();
    test_back_to_back();
    test_bias_relu();
    test_stall();
    test_acc_saturate();
    test_psum_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
